// File: rtl/rv32_bus_pkg.sv
// Shared types and constants for the rv32 memory-bus arbiter.
//   arb_state_t : arbiter FSM state
//   grant_t     : arbitration winner of the current IDLE cycle
//   BE_WORD     : full-word byte enable used by instruction fetches
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/rv32_mod_bus_timeout.sv
// Bus transaction watchdog.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the count (held while the arbiter is idle)
//   enable     : count one waiting cycle
//   expired    : count has reached TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES = 0)
module rv32_mod_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // Count stops at the limit so it can never wrap back below it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/rv32_mod_bus_arbiter.sv
// Two-master (fetch, load/store) to one-slave memory bus arbiter.
// A granted transaction owns the bus until the slave acks/errors or the
// watchdog fires; data wins ties unless the fetch has been starved.
//   clk, reset          : clock, asynchronous active-low reset
//   instr_*             : fetch master (req/addr in, ack/err/data_o out)
//   data_*              : load/store master (req/wr/be/addr/data_i in, ack/err/data_o out)
//   bus_*               : slave side (req/wr/be/addr/data_o out, data_i/ack/err in)
module rv32_mod_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int unsigned SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  arb_state_t    state;
  grant_t        winner;
  logic [SW-1:0] streak;
  logic          granted;
  logic          grant_i;
  logic          grant_d;
  logic          expired;
  logic          resp_ack;
  logic          resp_err;
  logic          streak_full;

  assign granted     = (state != IDLE);
  assign grant_i     = (state == GRANT_I);
  assign grant_d     = (state == GRANT_D);
  assign streak_full = (streak == SW'(MAX_DATA_STREAK));

  // Arbitration: data by default, fetch once the data streak is exhausted.
  always_comb begin
    winner = GRANT_NONE;
    if (state == IDLE) begin
      if (data_req && (!instr_req || !streak_full)) begin
        winner = GRANT_DATA;
      end else if (instr_req) begin
        winner = GRANT_INSTR;
      end
    end
  end

  // Slave response beats the watchdog; err beats ack.
  assign resp_err = granted && (bus_err || (!bus_ack && expired));
  assign resp_ack = granted && bus_ack && !bus_err;

  assign instr_ack    = grant_i && resp_ack;
  assign instr_err    = grant_i && resp_err;
  assign data_ack     = grant_d && resp_ack;
  assign data_err     = grant_d && resp_err;
  assign instr_data_o = grant_i ? bus_data_i : 32'h0;
  assign data_data_o  = grant_d ? bus_data_i : 32'h0;
  assign bus_req      = granted;

  rv32_mod_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (granted && !bus_ack && !bus_err),
    .expired(expired)
  );

  // Arbiter FSM, captured bus request and starvation streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      streak     <= '0;
      bus_wr     <= 1'b0;
      bus_be     <= 4'h0;
      bus_addr   <= 32'h0;
      bus_data_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          case (winner)
            GRANT_INSTR: begin
              state      <= GRANT_I;
              bus_addr   <= instr_addr;
              bus_wr     <= 1'b0;
              bus_be     <= BE_WORD;
              bus_data_o <= 32'h0;
              streak     <= '0;
            end
            GRANT_DATA: begin
              state      <= GRANT_D;
              bus_addr   <= data_addr;
              bus_wr     <= data_wr;
              bus_be     <= data_be;
              bus_data_o <= data_data_i;
              if (!instr_req) begin
                streak <= '0;
              end else if (!streak_full) begin
                streak <= streak + SW'(1);
              end
            end
            default: begin
              if (!instr_req) begin
                streak <= '0;
              end
            end
          endcase
        end
        GRANT_I, GRANT_D: begin
          if (bus_ack || bus_err || expired) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Self-checking bench for rv32_mod_bus_arbiter: directed scenarios followed
// by randomized master/slave traffic, all checked cycle by cycle against a
// transaction-level reference model.
module tb_rv32_mod_bus_arbiter;

  localparam int TO = 16;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_o;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_data_o;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack;
  logic        bus_err;

  rv32_mod_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .MAX_DATA_STREAK(MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_ack   (instr_ack),
    .instr_err   (instr_err),
    .instr_data_o(instr_data_o),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_data_i (data_data_i),
    .data_ack    (data_ack),
    .data_err    (data_err),
    .data_data_o (data_data_o),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_be      (bus_be),
    .bus_addr    (bus_addr),
    .bus_data_o  (bus_data_o),
    .bus_data_i  (bus_data_i),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the transaction currently owning the bus, how long it
  // has waited, and how many data grants have passed a waiting fetch.
  bit          m_busy;
  bit          m_own_d;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_wr;
  logic [3:0]  m_be;
  int          m_wait;
  int          m_streak;

  // Responses the model expected this cycle, and DUT values observed.
  bit r_i, r_d;
  bit o_iack, o_dack, o_derr, o_breq;

  // Master-side protocol state used to build stimulus.
  bit          i_pend;
  logic [31:0] i_a;
  bit          d_pend;
  bit          d_w;
  logic [3:0]  d_be;
  logic [31:0] d_a;
  logic [31:0] d_d;
  int          s_lat;

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_wait = 0; m_streak = 0;
    i_pend = 0; d_pend = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dd,
                      input bit sa, input bit se, input logic [31:0] sd);
    bit to_x, ack_x, err_x;
    @(posedge clk);
    #1;
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_wr = dw; data_be = dbe; data_addr = da; data_data_i = dd;
    bus_ack = sa; bus_err = se; bus_data_i = sd;
    #3;
    to_x  = m_busy && !sa && (m_wait == TO);
    ack_x = m_busy && sa && !se;
    err_x = m_busy && (se || to_x);
    r_i   = !m_own_d && (ack_x || err_x);
    r_d   = m_own_d && (ack_x || err_x);
    o_iack = instr_ack; o_dack = data_ack; o_derr = data_err; o_breq = bus_req;
    check_eq("bus_req",   32'(bus_req),   32'(m_busy));
    check_eq("instr_ack", 32'(instr_ack), 32'(ack_x && !m_own_d));
    check_eq("instr_err", 32'(instr_err), 32'(err_x && !m_own_d));
    check_eq("data_ack",  32'(data_ack),  32'(ack_x && m_own_d));
    check_eq("data_err",  32'(data_err),  32'(err_x && m_own_d));
    check_eq("instr_data", instr_data_o, (m_busy && !m_own_d) ? sd : 32'h0);
    check_eq("data_data",  data_data_o,  (m_busy && m_own_d) ? sd : 32'h0);
    if (m_busy) begin
      check_eq("bus_addr", bus_addr, m_addr);
      check_eq("bus_wr", 32'(bus_wr), 32'(m_wr));
      check_eq("bus_be", 32'(bus_be), 32'(m_be));
      if (m_own_d) check_eq("bus_data_o", bus_data_o, m_wdata);
    end
    if (m_busy) begin
      if (ack_x || err_x) m_busy = 0;
      else m_wait++;
    end else if (dr && (!ir || m_streak < MS)) begin
      m_busy = 1; m_own_d = 1; m_wait = 0;
      m_addr = da; m_wr = dw; m_be = dbe; m_wdata = dd;
      m_streak = ir ? ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
    end else if (ir) begin
      m_busy = 1; m_own_d = 0; m_wait = 0;
      m_addr = ia; m_wr = 0; m_be = 4'hF;
      m_streak = 0;
    end else begin
      m_streak = 0;
    end
  endtask

  // Cycle driven from the current master protocol state.
  task automatic cyc(input bit sa, input bit se, input logic [31:0] sd);
    step(i_pend, i_a, d_pend, d_w, d_be, d_a, d_d, sa, se, sd);
    if (r_i) i_pend = 0;
    if (r_d) d_pend = 0;
  endtask

  task automatic new_data(input bit w, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    d_pend = 1; d_w = w; d_be = be; d_a = a; d_d = d;
  endtask

  // Serve the pending fetch with an immediate ack, bounded.
  task automatic serve_fetch(input logic [31:0] a, input string tag);
    int n;
    i_pend = 1; i_a = a; n = 0;
    while (i_pend && n < 10) begin
      cyc(m_busy, 1'b0, 32'hC0DE_0000 + 32'(n));
      n++;
    end
    check_eq(tag, 32'(i_pend), 32'h0);
  endtask

  initial begin
    int n, nd, dfirst, dtot;
    bit seen_i, sa, se;
    int k;

    reset = 1'b0;
    instr_req = 0; instr_addr = 0; data_req = 0; data_wr = 0; data_be = 0;
    data_addr = 0; data_data_i = 0; bus_data_i = 0; bus_ack = 0; bus_err = 0;
    model_reset();
    d_w = 0; d_be = 0; d_a = 0; d_d = 0; i_a = 0; s_lat = 0;
    #12;
    check_eq("rst_bus_req", 32'(bus_req), 32'h0);
    check_eq("rst_acks", 32'({instr_ack, instr_err, data_ack, data_err}), 32'h0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_be_wr", 32'({bus_be, bus_wr}), 32'h0);
    #6 reset = 1'b1;

    // Single fetch, slave acks two cycles after bus_req rises.
    i_pend = 1; i_a = 32'h100;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 32'hDEAD_BEEF);
    cyc(0, 0, 0);

    // Simultaneous fetch and store: store first, fetch after a gap.
    i_pend = 1; i_a = 32'h104;
    new_data(1'b1, 4'h3, 32'h2000, 32'h1234);
    cyc(0, 0, 0); cyc(1, 0, 32'h1111); cyc(0, 0, 0); cyc(1, 0, 32'h2222);
    cyc(0, 0, 0);

    // Starvation: fetch held against six back-to-back data requests.
    i_pend = 1; i_a = 32'h200; nd = 6; dfirst = 0; dtot = 0; seen_i = 0; n = 0;
    while ((i_pend || d_pend || nd > 0) && n < 60) begin
      if (!d_pend && nd > 0) begin
        new_data(1'b0, 4'hF, 32'h4000 + 32'(nd * 4), 32'h0);
        nd--;
      end
      cyc(m_busy, 1'b0, 32'h5A5A_0000 + 32'(n));
      if (o_iack) seen_i = 1;
      if (o_dack) begin
        dtot++;
        if (!seen_i) dfirst++;
      end
      n++;
    end
    check_eq("starve_data_before_fetch", 32'(dfirst), 32'd4);
    check_eq("starve_fetch_served", 32'(seen_i), 32'h1);
    check_eq("starve_data_total", 32'(dtot), 32'd6);
    cyc(0, 0, 0);

    // Timeout on a silent slave, then a fetch is still served.
    new_data(1'b0, 4'hF, 32'h3000, 32'h0);
    cyc(0, 0, 0);
    n = 0; k = 0;
    while (k < 40) begin
      cyc(0, 0, 32'hFFFF_FFFF);
      if (o_derr) break;
      if (o_breq) n++;
      k++;
    end
    check_eq("timeout_cycles", 32'(n), 32'(TO));
    cyc(0, 0, 0);
    serve_fetch(32'h108, "fetch_after_timeout");
    cyc(0, 0, 0);

    // ack and err together on a fetch: err wins, data side untouched.
    i_pend = 1; i_a = 32'h10C;
    cyc(0, 0, 0); cyc(1, 1, 32'h55);
    cyc(0, 0, 0);

    // Asynchronous reset during a data grant.
    new_data(1'b1, 4'hC, 32'h6000, 32'hABCD);
    cyc(0, 0, 0); cyc(0, 0, 0);
    @(posedge clk);
    #1 bus_ack = 1'b1; bus_err = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_eq("arst_bus_req", 32'(bus_req), 32'h0);
    check_eq("arst_acks", 32'({instr_ack, instr_err, data_ack, data_err}), 32'h0);
    check_eq("arst_data_o", data_data_o, 32'h0);
    check_eq("arst_bus_addr", bus_addr, 32'h0);
    #4;
    instr_req = 0; data_req = 0; bus_ack = 0;
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    serve_fetch(32'h110, "fetch_after_reset");
    cyc(0, 0, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_a = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0)
        new_data(1'($urandom), 4'($urandom), $urandom, $urandom);
      sa = 0; se = 0;
      if (m_busy) begin
        if (m_wait == 0) s_lat = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
        if (m_wait == s_lat) begin
          k = int'($urandom_range(0, 7));
          sa = (k != 0);
          se = (k <= 1);
        end
      end else begin
        sa = ($urandom_range(0, 7) == 0);
        se = ($urandom_range(0, 15) == 0);
      end
      cyc(sa, se, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
